// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, stop-bit framing check,
// and a receive FIFO that downstream logic drains with a ready/valid handshake.
module uart_rx_buffered #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 3_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              uart_rxd_in,
  output logic [7:0]                        byte_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_out,
  output logic                              framing_error_out,
  output logic                              overflow_out
);

  localparam int CYCLES_PER_BAUD = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BAUD       = CYCLES_PER_BAUD / 2;
  localparam int CNT_W           = $clog2(CYCLES_PER_BAUD);
  localparam int PTR_W           = $clog2(FIFO_DEPTH);
  localparam int COUNT_W         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t             state, next_state;
  logic               rxd_meta, rxd_s;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               half_done, full_done;
  logic               baud_tick, shift_en, push_req, frame_err;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               full, empty, push, pop;

  // Preset to idle-high so releasing reset can never look like a start bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd_in;
      rxd_s    <= rxd_meta;
    end
  end

  assign half_done = (baud_cnt == CNT_W'(HALF_BAUD - 1));
  assign full_done = (baud_cnt == CNT_W'(CYCLES_PER_BAUD - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!rxd_s) next_state = START;
      START:     if (half_done) next_state = rxd_s ? IDLE : DATA;
      DATA:      if (full_done && bit_idx == 3'd7) next_state = STOP;
      STOP:      if (full_done) next_state = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    baud_tick = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state)
      START: baud_tick = half_done;
      DATA: begin
        baud_tick = full_done;
        shift_en  = full_done;
      end
      STOP: begin
        baud_tick = full_done;
        push_req  = full_done && rxd_s;
        frame_err = full_done && !rxd_s;
      end
      default: ;
    endcase
  end

  // Baud counter restarts at every sample point so each bit is timed from the previous sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (state == IDLE || state == WAIT_HIGH || baud_tick) baud_cnt <= '0;
      else                                                  baud_cnt <= baud_cnt + CNT_W'(1);
      if (state == START)  bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift_reg <= {rxd_s, shift_reg[7:1]};
    end
  end

  assign full  = (count == COUNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && ready_in;
  assign push  = push_req && (!full || pop);

  // When full, a simultaneous pop frees the slot the write pointer already points at.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      framing_error_out <= 1'b0;
      overflow_out      <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
      framing_error_out <= frame_err;
      overflow_out      <= push_req && full && !pop;
    end
  end

  assign byte_out  = mem[rd_ptr];
  assign valid_out = !empty;
  assign count_out = count;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: serial frames in, ready/valid bytes and status pulses out.
module tb_uart_rx_buffered;

  localparam int CPB = 33;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] byte_out;
  logic       valid_out;
  logic [4:0] count_out;
  logic       fe, ov;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int long_pulse = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic valid_prev = 1'b0;
  logic [7:0] got[$];

  uart_rx_buffered dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .uart_rxd_in(rxd),
    .byte_out(byte_out),
    .valid_out(valid_out),
    .ready_in(ready),
    .count_out(count_out),
    .framing_error_out(fe),
    .overflow_out(ov)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes just after the falling edge, when inputs driven on that edge have settled.
  always @(negedge clk) begin
    #1;
    if (valid_out && ready) got.push_back(byte_out);
    if (valid_out) valid_cycles++;
    if (valid_out && !valid_prev) rise_cyc = cyc;
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if ((fe && fe_prev) || (ov && ov_prev) || (fe && ov)) long_pulse++;
    fe_prev    = fe;
    ov_prev    = ov;
    valid_prev = valid_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD;
  endfunction

  task automatic clear_monitors();
    got.delete();
    fe_cnt       = 0;
    ov_cnt       = 0;
    valid_cycles = 0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; leaves the line at the stop level so frames can abut.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    rxd = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      rxd = data[i];
    end
    repeat (CPB) @(negedge clk);
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] partial;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_byte", byte_out, 0);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_count", count_out, 0);
    checkOutput("rst_fe", fe, 0);
    checkOutput("rst_ov", ov, 0);
    rst_n = 1'b1;
    idle(10);

    ready = 1'b1;
    clear_monitors();
    applyStimulus(8'hA5, 1'b1);
    idle(40);
    checkOutput("t1_nbytes", got.size(), 1);
    checkOutput("t1_byte", got_at(0), 32'hA5);
    checkOutput("t1_valid_cycles", valid_cycles, 1);
    checkOutput("t1_count", count_out, 0);
    checkOutput("t1_fe", fe_cnt, 0);
    checkOutput("t1_ov", ov_cnt, 0);
    checkOutput("t1_latency_window", ((rise_cyc - start_cyc) >= 315) && ((rise_cyc - start_cyc) <= 317), 1);

    ready = 1'b0;
    clear_monitors();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    idle(20);
    checkOutput("t2_count", count_out, 3);
    checkOutput("t2_valid", valid_out, 1);
    checkOutput("t2_head", byte_out, 32'h00);
    ready = 1'b1;
    idle(10);
    ready = 1'b0;
    checkOutput("t2_nbytes", got.size(), 3);
    checkOutput("t2_b0", got_at(0), 32'h00);
    checkOutput("t2_b1", got_at(1), 32'hFF);
    checkOutput("t2_b2", got_at(2), 32'h3C);
    checkOutput("t2_count_after", count_out, 0);

    clear_monitors();
    for (int b = 1; b <= 16; b++) applyStimulus(8'(b), 1'b1);
    idle(20);
    checkOutput("t3_count_full", count_out, 16);
    checkOutput("t3_ov_before", ov_cnt, 0);
    applyStimulus(8'h11, 1'b1);
    idle(20);
    checkOutput("t3_count_still_full", count_out, 16);
    checkOutput("t3_ov_once", ov_cnt, 1);
    checkOutput("t3_head", byte_out, 32'h01);
    ready = 1'b1;
    idle(30);
    ready = 1'b0;
    checkOutput("t3_nbytes", got.size(), 16);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("t3_b%0d", i), got_at(i), 32'(i + 1));
    checkOutput("t3_count_empty", count_out, 0);
    checkOutput("t3_fe", fe_cnt, 0);

    ready = 1'b1;
    clear_monitors();
    applyStimulus(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    idle(2 * CPB);
    applyStimulus(8'h7E, 1'b1);
    idle(40);
    checkOutput("t4_fe_once", fe_cnt, 1);
    checkOutput("t4_ov", ov_cnt, 0);
    checkOutput("t4_nbytes", got.size(), 1);
    checkOutput("t4_byte", got_at(0), 32'h7E);

    clear_monitors();
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(60);
    checkOutput("t5_count", count_out, 0);
    checkOutput("t5_nbytes", got.size(), 0);
    checkOutput("t5_valid_cycles", valid_cycles, 0);
    checkOutput("t5_fe", fe_cnt, 0);
    checkOutput("t5_ov", ov_cnt, 0);
    applyStimulus(8'h81, 1'b1);
    idle(40);
    checkOutput("t5_after_nbytes", got.size(), 1);
    checkOutput("t5_after_byte", got_at(0), 32'h81);

    ready = 1'b0;
    clear_monitors();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    idle(20);
    checkOutput("t6_count_before", count_out, 2);
    partial = 8'hC3;
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(negedge clk);
      rxd = partial[i];
    end
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", valid_out, 0);
    checkOutput("t6_async_count", count_out, 0);
    checkOutput("t6_async_byte", byte_out, 0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    clear_monitors();
    ready = 1'b1;
    applyStimulus(8'h12, 1'b1);
    idle(40);
    checkOutput("t6_nbytes", got.size(), 1);
    checkOutput("t6_byte", got_at(0), 32'h12);
    checkOutput("t6_count", count_out, 0);
    checkOutput("t6_fe", fe_cnt, 0);
    checkOutput("pulse_width", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
